// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit holding the architectural
//               HI/LO registers. Handles MULT, MULTU, DIV, DIVU, MTHI and
//               MTLO. Multiplies use shift-add and divides use restoring
//               division, one bit per cycle. Both work on operand
//               magnitudes, and a final FIX cycle applies sign correction.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    // Multiply: {upper accumulator, remaining multiplier bits}.
    // Divide  : {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] r_prod;
    // Multiplicand (multiply) or divisor (divide) magnitude.
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div;
    logic               r_sgn_x;    // sign(a) ^ sign(b) for signed ops
    logic               r_sgn_a;    // sign(a) for signed divide remainder
    logic               r_dbz;      // divide by zero
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    // Launch decode, only meaningful in IDLE; cancel suppresses any start.
    logic               w_idle;
    logic               w_accept;
    logic               w_move;
    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && start && !cancel && !op[2];
    assign w_move   = w_idle && start && !cancel && op[2] && !op[1];
    assign w_signed = !op[0];
    assign w_abs_a  = (w_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign w_abs_b  = (w_signed && in_b[WIDTH-1]) ? -in_b : in_b;

    // Shift-add multiply step: conditionally add the multiplicand into the
    // upper half, then shift the whole product right by one.
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_msum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_prod[0] ? r_opb : {WIDTH{1'b0}})};
    assign w_mul_next = {w_msum, r_prod[WIDTH-1:1]};

    // Restoring divide step: shift the next dividend bit into the remainder,
    // trial-subtract the divisor, keep the difference if it did not borrow.
    // The partial remainder is always below the divisor, so WIDTH+1 bits
    // hold the trial value and the borrow lands in the top bit.
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_trial    = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_diff     = w_trial - {1'b0, r_opb};
    assign w_qbit     = !w_diff[WIDTH];
    assign w_div_next = {(w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                         r_prod[WIDTH-2:0], w_qbit};

    // Sign correction applied in FIX. A zero divisor gives an all-ones
    // quotient and a remainder equal to the dividend magnitude; negating the
    // remainder by sign(a) restores the original dividend for HI.
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod_fix = r_sgn_x ? -r_prod : r_prod;
    assign w_rem      = r_prod[2*WIDTH-1:WIDTH];
    assign w_quo      = r_prod[WIDTH-1:0];

    // Select HI/LO results for the finishing write.
    always_comb begin
        w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_hi = r_sgn_a ? -w_rem : w_rem;
            if (r_dbz) begin
                w_fix_lo = {WIDTH{1'b1}};
            end else begin
                w_fix_lo = r_sgn_x ? -w_quo : w_quo;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the counter reaching one ends the iteration phase.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_CALC;
                end
            end
            S_CALC: begin
                if (cancel) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == C_CNT_ONE) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode; everything here is a plain register or state decode.
    always_comb begin
        busy = (r_state == S_CALC) || (r_state == S_FIX);
        done = r_done;
        hi   = r_hi;
        lo   = r_lo;
    end

    // Datapath: operand capture, iteration, HI/LO writes and done pulse.
    // Multiplication is commutative, so both op classes load {0,|a|} into
    // the product register and |b| into r_opb.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_sgn_x  <= 1'b0;
            r_sgn_a  <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= C_CNT_LOAD;
                        r_prod   <= {{WIDTH{1'b0}}, w_abs_a};
                        r_opb    <= w_abs_b;
                        r_is_div <= op[1];
                        r_sgn_x  <= w_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                        r_sgn_a  <= w_signed && in_a[WIDTH-1];
                        r_dbz    <= op[1] && (in_b == {WIDTH{1'b0}});
                    end else if (w_move) begin
                        if (op[0]) begin
                            r_lo <= in_a;
                        end else begin
                            r_hi <= in_a;
                        end
                    end
                end
                S_CALC: begin
                    if (!cancel) begin
                        r_cnt  <= r_cnt - C_CNT_ONE;
                        r_prod <= r_is_div ? w_div_next : w_mul_next;
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Expected HI/LO pairs are
//               queued when an operation is launched and compared when done
//               pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] sb_q[$];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .in_a   (in_a),
        .in_b   (in_b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference using native wide arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, q, r;
        logic [63:0] ua, ub;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (o)
            3'd0: return sa * sbv;
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a negedge; drives start for exactly one cycle.
    task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        op    = o;
        in_a  = a;
        in_b  = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd6;
    endtask

    // Returns at the negedge where done is high (or after the budget).
    task automatic wait_done(input string tag);
        int n;
        int guard;
        logic [63:0] e;
        n = 0;
        guard = 0;
        while (!done && guard < 200) begin
            if (busy) n++;
            guard++;
            @(negedge clk);
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busycyc"}, 64'(n), 64'd33);
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
        chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        sb_q.push_back({eh, el});
        launch(o, a, b);
        wait_done(tag);
    endtask

    initial begin
        int n_done;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] re;

        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'd6;
        in_a   = '0;
        in_b   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mult_m3x5", 3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);

        run_op("multu_ff", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_ff", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        run_op("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_7_2", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("divu_dbz", 3'd3, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("div_dbz_neg", 3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

        // MTHI then MTLO on consecutive cycles.
        start = 1'b1;
        op    = 3'd4;
        in_a  = 32'h1234;
        @(negedge clk);
        chk("mthi_hi", 64'(hi), 64'h1234);
        chk("mthi_busy", 64'(busy), 64'd0);
        op    = 3'd5;
        in_a  = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd6;
        chk("mtlo_lo", 64'(lo), 64'h5678);
        chk("mtlo_hi", 64'(hi), 64'h1234);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);

        // Cancel mid-multiply: no done, HI/LO retained.
        launch(3'd0, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        n_done = 0;
        repeat (40) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("cancel_nodone", 64'(n_done), 64'd0);
        chk("cancel_hi", 64'(hi), 64'h1234);
        chk("cancel_lo", 64'(lo), 64'h5678);

        // Cancel in IDLE beats start.
        cancel = 1'b1;
        launch(3'd0, 32'd2, 32'd3);
        cancel = 1'b0;
        chk("idle_cancel_busy", 64'(busy), 64'd0);

        // Reset mid-divide.
        launch(3'd3, 32'd9, 32'd4);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);

        // Back-to-back: second start issued in the done cycle.
        run_op("b2b_first", 3'd3, 32'd9, 32'd4, 32'd1, 32'd2);
        run_op("b2b_second", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

        // Randomised operations against the reference model.
        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom;
            if (i == 4) rb = 32'($urandom_range(1, 9));
            re = model(ro, ra, rb);
            run_op($sformatf("rand%0d", i), ro, ra, rb, re[63:32], re[31:0]);
        end

        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
